// File: rtl/masked_random_source_pkg.sv
// masked_random_source_pkg: shared LFSR constants, types and lane-count helper
package masked_random_source_pkg;
  localparam bit [31:0] LFSR_POLY = 32'h80200003;
  typedef bit [31:0] lfsr_word_t;
  typedef enum logic {SEED, RUN} src_state_t;
  function automatic int num_lfsr_lanes(int n);
    return (n + 31) / 32;
  endfunction
endpackage

// File: rtl/masked_random_source_if.sv
// masked_random_source_if: seeding handshake and randomness output bundle
interface masked_random_source_if #(parameter int NUM_RANDOM = 80);
  logic [31:0] in_seed;
  logic in_seed_valid;
  logic out_seed_ready;
  logic in_reseed;
  logic in_enable;
  logic [NUM_RANDOM-1:0] out_random;
  logic out_valid;
  modport master (
    output in_seed, in_seed_valid, in_reseed, in_enable,
    input out_seed_ready, out_random, out_valid
  );
  modport slave (
    input in_seed, in_seed_valid, in_reseed, in_enable,
    output out_seed_ready, out_random, out_valid
  );
endinterface

// File: rtl/lfsr32_advance.sv
// lfsr32_advance: combinational STEPS-fold Galois LFSR step
module lfsr32_advance
  import masked_random_source_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic [31:0] in_s,
  output logic [31:0] out_s
);
  always_comb begin
    out_s = in_s;
    for (int k = 0; k < STEPS; k++)
      out_s = (out_s >> 1) ^ (out_s[0] ? LFSR_POLY : 32'h0);
  end
endmodule

// File: rtl/register.sv
// register: plain clocked storage with synchronous clear
module register #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : d;
endmodule

// File: rtl/masked_random_source.sv
// masked_random_source: seeded bank of 32-bit LFSR lanes feeding masked gadgets
module masked_random_source
  import masked_random_source_pkg::*;
#(
  parameter int NUM_RANDOM = 80,
  parameter int STEPS = 32
) (
  input logic in_clock,
  input logic in_reset,
  masked_random_source_if.slave bus
);
  localparam int NL = num_lfsr_lanes(NUM_RANDOM);
  localparam int IW = NL > 1 ? $clog2(NL) : 1;
  src_state_t state;
  logic [IW-1:0] idx;
  logic ready, valid;
  logic [31:0] lane_q [NL];
  logic [31:0] lane_d [NL];
  logic [31:0] adv [NL];
  logic [31:0] seed_word;
  logic take, last, step;
  // all-zero would lock the LFSR, so it is replaced by 1
  assign seed_word = bus.in_seed == 32'h0 ? 32'h1 : bus.in_seed;
  assign take = ready & bus.in_seed_valid;
  assign last = idx == IW'(NL - 1);
  assign step = valid & bus.in_enable;
  for (genvar i = 0; i < NL; i++) begin : g_lane
    localparam int W = NUM_RANDOM - 32 * i < 32 ? NUM_RANDOM - 32 * i : 32;
    lfsr32_advance #(.STEPS(STEPS)) u_adv (.in_s(lane_q[i]), .out_s(adv[i]));
    assign lane_d[i] = take && idx == IW'(i) ? seed_word : step ? adv[i] : lane_q[i];
    register #(.WIDTH(32)) u_lane (.clk(in_clock), .rst(in_reset), .d(lane_d[i]), .q(lane_q[i]));
    assign bus.out_random[32*i +: W] = lane_q[i][W-1:0];
  end
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state <= SEED;
      idx <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
    end else if (state == SEED) begin
      if (take) begin
        idx <= last ? '0 : idx + 1'b1;
        state <= last ? RUN : SEED;
        ready <= !last;
        valid <= last;
      end
    end else if (bus.in_reseed) begin
      state <= SEED;
      idx <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
    end
  end
  assign bus.out_seed_ready = ready;
  assign bus.out_valid = valid;
endmodule

// File: tb/tb_masked_random_source.sv
// tb_masked_random_source: directed table plus randomized model check of the LFSR source
module tb_masked_random_source;
  localparam int STEPS_B = 7;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  masked_random_source_if #(.NUM_RANDOM(40)) ia ();
  masked_random_source_if #(.NUM_RANDOM(80)) ib ();
  masked_random_source #(.NUM_RANDOM(40), .STEPS(1)) dut_a (.in_clock(clk), .in_reset(rst), .bus(ia));
  masked_random_source #(.NUM_RANDOM(80), .STEPS(STEPS_B)) dut_b (.in_clock(clk), .in_reset(rst), .bus(ib));
  typedef struct {
    logic sv;
    logic [31:0] seed;
    logic en;
    logic rs;
    logic ev;
    logic er;
    logic [39:0] rnd;
  } vec_t;
  vec_t tbl [14];
  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic drive_a(logic sv, logic [31:0] seed, logic en, logic rs);
    ia.in_seed_valid = sv;
    ia.in_seed = seed;
    ia.in_enable = en;
    ia.in_reseed = rs;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] lfsr_n(logic [31:0] s, int n);
    logic [63:0] t;
    for (int k = 0; k < n; k++) begin
      t = {32'h0, s};
      s = t[0] ? (s / 2) ^ 32'h80200003 : s / 2;
    end
    return s;
  endfunction
  logic [31:0] mb [3];
  logic [95:0] cat;
  bit run_b;
  int idx_b;
  logic sv, en, rs;
  logic [31:0] sd;
  initial begin
    drive_a(0, 0, 0, 0);
    ib.in_seed_valid = 0;
    ib.in_seed = 0;
    ib.in_enable = 0;
    ib.in_reseed = 0;
    tbl[0]  = '{1, 32'h1,    0, 0, 0, 1, 40'h00_00000001};
    tbl[1]  = '{1, 32'h5,    0, 0, 1, 0, 40'h05_00000001};
    tbl[2]  = '{0, 32'h0,    1, 0, 1, 0, 40'h01_80200003};
    tbl[3]  = '{0, 32'h0,    1, 0, 1, 0, 40'h03_C0300002};
    tbl[4]  = '{1, 32'hDEAD, 0, 0, 1, 0, 40'h03_C0300002};
    tbl[5]  = '{1, 32'hBEEF, 0, 0, 1, 0, 40'h03_C0300002};
    tbl[6]  = '{0, 32'h0,    0, 0, 1, 0, 40'h03_C0300002};
    tbl[7]  = '{0, 32'h0,    0, 0, 1, 0, 40'h03_C0300002};
    tbl[8]  = '{0, 32'h0,    0, 0, 1, 0, 40'h03_C0300002};
    tbl[9]  = '{0, 32'h0,    1, 1, 0, 1, 40'h02_60180001};
    tbl[10] = '{1, 32'h0,    0, 0, 0, 1, 40'h02_00000001};
    tbl[11] = '{0, 32'h0,    1, 1, 0, 1, 40'h02_00000001};
    tbl[12] = '{1, 32'h77,   0, 0, 1, 0, 40'h77_00000001};
    tbl[13] = '{0, 32'h0,    1, 0, 1, 0, 40'h38_80200003};
    tick();
    tick();
    rst = 0;
    chk("reset_valid", 80'(ia.out_valid), 80'd0);
    chk("reset_ready", 80'(ia.out_seed_ready), 80'd1);
    chk("reset_random", 80'(ia.out_random), 80'd0);
    chk("reset_b", {ib.out_random[77:0], ib.out_valid, ib.out_seed_ready}, 80'd1);
    for (int i = 0; i < 14; i++) begin
      drive_a(tbl[i].sv, tbl[i].seed, tbl[i].en, tbl[i].rs);
      tick();
      chk($sformatf("row%0d_valid", i), 80'(ia.out_valid), 80'(tbl[i].ev));
      chk($sformatf("row%0d_ready", i), 80'(ia.out_seed_ready), 80'(tbl[i].er));
      chk($sformatf("row%0d_random", i), 80'(ia.out_random), 80'(tbl[i].rnd));
    end
    rst = 1;
    drive_a(0, 0, 0, 0);
    tick();
    rst = 0;
    drive_a(1, 32'hAA, 0, 0);
    tick();
    chk("part_seed_random", 80'(ia.out_random), 80'h00_000000AA);
    rst = 1;
    drive_a(1, 32'h33, 1, 0);
    tick();
    rst = 0;
    chk("rst_mid_random", 80'(ia.out_random), 80'd0);
    chk("rst_mid_flags", {ia.out_valid, ia.out_seed_ready}, 80'b01);
    drive_a(1, 32'h11, 0, 0);
    tick();
    chk("reseed1_valid", 80'(ia.out_valid), 80'd0);
    chk("reseed1_random", 80'(ia.out_random), 80'h00_00000011);
    drive_a(1, 32'h22, 0, 0);
    tick();
    chk("reseed2_valid", 80'(ia.out_valid), 80'd1);
    chk("reseed2_random", 80'(ia.out_random), 80'h22_00000011);
    drive_a(0, 0, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    mb = '{32'h0, 32'h0, 32'h0};
    run_b = 0;
    idx_b = 0;
    for (int c = 0; c < 400; c++) begin
      sv = 1'($urandom_range(0, 1));
      sd = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom;
      en = $urandom_range(0, 9) < 6;
      rs = $urandom_range(0, 19) == 0;
      if (!run_b) begin
        if (sv) begin
          mb[idx_b] = sd == 0 ? 32'h1 : sd;
          idx_b++;
          if (idx_b == 3) begin
            run_b = 1;
            idx_b = 0;
          end
        end
      end else begin
        if (en)
          for (int l = 0; l < 3; l++) mb[l] = lfsr_n(mb[l], STEPS_B);
        if (rs) begin
          run_b = 0;
          idx_b = 0;
        end
      end
      ib.in_seed_valid = sv;
      ib.in_seed = sd;
      ib.in_enable = en;
      ib.in_reseed = rs;
      tick();
      cat = {mb[2], mb[1], mb[0]};
      chk($sformatf("rand%0d_flags", c), {ib.out_valid, ib.out_seed_ready}, {run_b, !run_b});
      chk($sformatf("rand%0d_random", c), ib.out_random, cat[79:0]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
